noc_tok_link_buf: RTL
=====================

# noc_tok_link_buf

Parametrised multi-channel buffer for NoC token links (data/head/tail/vld/rdy flit interfaces), placed at partition crossings such as center↔east and east↔soc. Each channel has its own flit FIFO of configurable depth and width, and can run in cut-through or store-and-forward mode. Each channel reports its occupancy and, when compiled in, sticky head/tail framing errors. It replaces hard-wired per-link token crossings with one instance per link bundle.

## Interface
- NUM_CH, 2: number of independent token channels (1..8)
- DATA_W, 42: flit data width; narrower links tie off the MSBs (e.g. 32-bit links)
- DEPTH, 4: FIFO entries per channel (2..32, power of two not required)
- PKT_MODE, 0: 0 = cut-through, 1 = store-and-forward
- OCC_W, $clog2(DEPTH+1): occupancy width (derived, not overridable)

Ports:
- i_noc_clk  in  1  NoC clock
- i_noc_rst_n  in  1  asynchronous, active-low reset
- scan_en  in  1  scan enable; no functional effect
- i_ing_data  in  NUM_CH×DATA_W  ingress flit data
- i_ing_head  in  NUM_CH  ingress head flag
- i_ing_tail  in  NUM_CH  ingress tail flag
- i_ing_vld  in  NUM_CH  ingress valid
- o_ing_rdy  out  NUM_CH  ingress ready
- o_egr_data  out  NUM_CH×DATA_W  egress flit data
- o_egr_head  out  NUM_CH  egress head flag
- o_egr_tail  out  NUM_CH  egress tail flag
- o_egr_vld  out  NUM_CH  egress valid
- i_egr_rdy  in  NUM_CH  egress ready
- o_occ  out  NUM_CH×OCC_W  per-channel FIFO occupancy
- i_err_clr  in  1  pulse; clears all sticky error bits (macro-dependent)
- o_frame_err  out  NUM_CH×2  sticky framing errors (macro-dependent)

## Operation
- Channels are fully independent; no arbitration between them.
- Ingress transfer occurs when vld&rdy. The flit {data, head, tail} is written to the FIFO unchanged.
- Egress transfer occurs when vld&rdy. The FIFO pops, and vld/data must hold while vld&!rdy.
- o_ing_rdy = !full, registered.
- o_egr_vld is set from a non-empty FIFO, subject to the mode gate described below.
- Cut-through (PKT_MODE=0): egress is gated only by non-empty.
- Store-and-forward (PKT_MODE=1):
  - pkt_cnt counts complete packets held in the FIFO. It increments on an accepted ingress tail and decrements on an accepted egress tail; both in the same cycle leave it unchanged.
  - Egress state machine, per channel:
    - IDLE → SEND when head-of-FIFO is a head flit and either pkt_cnt>0 or (full && pkt_cnt==0). The second condition is a forced release, which prevents deadlock on packets longer than DEPTH.
    - SEND → IDLE on an accepted egress tail.
    - In SEND, flits flow cut-through.
  - A single-flit packet (head&tail) counts as a complete packet.
- o_occ reflects the entry count after each clock edge. Range is 0..DEPTH.

## Timing
- Reset values: o_ing_rdy=0, o_egr_vld=0, o_egr_head/tail/data=0, o_occ=0, o_frame_err=0, state=IDLE, pkt_cnt=0.
- o_ing_rdy rises on the first clock edge after reset release.
- Minimum latency is 1 cycle: a flit accepted at edge N shows o_egr_vld at N+1. There is no combinational path from ingress to egress.
- Throughput is 1 flit/cycle/channel in cut-through for DEPTH≥2 under a continuous i_egr_rdy.
- Full: o_ing_rdy falls the cycle after the DEPTH-th write. A simultaneous pop and push at full keeps rdy low that cycle and raises it next cycle (registered ready, no bypass).
- Empty: a push and a pop in the same cycle at occupancy 1 leaves occupancy 1.
- Pointers wrap modulo DEPTH, non-power-of-two depths included.
- Asserting reset mid-packet drops all stored flits and returns the machine to IDLE. Upstream must re-send from a head flit.

## Configuration
- NOC_TOK_BUF_FRAME_CHK_EN defined:
  - Per channel, an ingress in_pkt flag tracks packet framing.
  - bit0 is set when a head arrives while in_pkt (missing tail).
  - bit1 is set when a non-head flit arrives while !in_pkt (missing head).
  - Bits are sticky until i_err_clr. A clear and a new error in the same cycle leaves the bit set.
  - Flits are still forwarded unmodified.
- Undefined: o_frame_err is tied to 0, i_err_clr is ignored, and no checker logic is present.

## Structure
- Package noc_tok_buf_pkg holds:
  - the error-bit index constants (FRAME_ERR_NO_TAIL=0, FRAME_ERR_NO_HEAD=1)
  - the egress state enum (IDLE, SEND)
  - the PKT_MODE constants
  - a parametrised flit-packing helper
- Sub-module noc_tok_buf_ch implements one channel (FIFO, pkt_cnt, state machine, checker). The top instantiates it NUM_CH times with generate.

## Test plan
- Reset, then 8 single-flit packets on ch0 with i_egr_rdy=1, DEPTH=4, PKT_MODE=0 → first o_egr_vld 1 cycle after the first accept, then one flit per cycle, data in order, o_occ ≤1.
- i_egr_rdy=0, push 5 flits with DEPTH=4 → 4 accepted, o_ing_rdy=0 after the 4th, o_occ=4. Release rdy → all 4 drain in order and rdy returns.
- PKT_MODE=1, 3-flit packet (head, body, tail) sent with 2-cycle gaps → o_egr_vld stays 0 until the cycle after the tail is accepted, then 3 back-to-back flits.
- PKT_MODE=1, DEPTH=4, 6-flit packet → forced release at occupancy 4 and pkt_cnt=0, the packet streams out, no deadlock, and the next packet waits for its tail again.
- Framing check enabled: head, then head (no tail), then a body flit after a tail → o_frame_err=2'b11. Pulse i_err_clr → 2'b00. All flits are still delivered.
- Reset asserted mid-packet with occupancy 3 → outputs return to reset values asynchronously, o_occ=0, and a new packet after release is forwarded correctly.

Source files
------------

// File: rtl/noc_tok_buf_pkg.sv
// noc_tok_buf_pkg
//   Shared definitions for the NoC token link buffer:
//     - framing error bit positions inside each channel's 2-bit o_frame_err
//     - egress state encoding used in store-and-forward mode
//     - PKT_MODE selector values
//     - flit packing helper producing {data, head, tail}
//   No ports (package).
package noc_tok_buf_pkg;

  localparam int FRAME_ERR_NO_TAIL = 0;
  localparam int FRAME_ERR_NO_HEAD = 1;

  localparam int PKT_MODE_CT  = 0;
  localparam int PKT_MODE_SAF = 1;

  // Widest supported flit payload; narrower links are zero-extended into it.
  localparam int DATA_MAX_W = 64;
  localparam int FLIT_MAX_W = DATA_MAX_W + 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } egr_state_e;

  // Packs a flit as {data, head, tail}; callers truncate to DATA_W+2 bits,
  // which keeps the low data bits followed by head and tail.
  function automatic logic [FLIT_MAX_W-1:0] flit_pack(
    input logic [DATA_MAX_W-1:0] data,
    input logic                  head,
    input logic                  tail
  );
    return {data, head, tail};
  endfunction

endpackage

// File: rtl/noc_tok_buf_ch.sv
// noc_tok_buf_ch
//   One token channel: flit FIFO of DEPTH entries, registered ingress ready,
//   registered egress flit/valid, occupancy, and in store-and-forward mode a
//   complete-packet counter plus IDLE/SEND egress gate.
//   Optional framing checker compiled in with NOC_TOK_BUF_FRAME_CHK_EN.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_data/i_head/i_tail     ingress flit, i_vld/o_rdy ingress handshake
//   o_data/o_head/o_tail     egress flit,  o_vld/i_rdy egress handshake
//   o_occ                    entries held after the last clock edge
//   i_err_clr, o_frame_err   sticky framing error clear / status
module noc_tok_buf_ch
  import noc_tok_buf_pkg::*;
#(
  parameter int DATA_W   = 42,
  parameter int DEPTH    = 4,
  parameter int PKT_MODE = 0,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_head,
  input  logic              i_tail,
  input  logic              i_vld,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_head,
  output logic              o_tail,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic [OCC_W-1:0]  o_occ,
  input  logic              i_err_clr,
  output logic [1:0]        o_frame_err
);

  localparam int FLIT_W = DATA_W + 2;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0]  OCC_ZERO  = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0]  DEPTH_C   = OCC_W'(DEPTH);
  localparam logic [FLIT_W-1:0] FLIT_ZERO = {FLIT_W{1'b0}};

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [OCC_W-1:0]  r_count, w_count_nxt, r_pkt_cnt, w_pkt_cnt_nxt;
  egr_state_e        r_state, w_state_aft, w_state_nxt;
  logic              r_rdy, r_vld, w_vld_nxt, w_push, w_pop, w_go;
  logic [FLIT_W-1:0] w_flit_in, w_head_ent, r_flit_out, w_flit_out_nxt;

  assign w_flit_in = FLIT_W'(flit_pack(DATA_MAX_W'(i_data), i_head, i_tail));
  assign w_push    = i_vld & r_rdy;
  assign w_pop     = r_vld & i_rdy;

  assign o_rdy  = r_rdy;
  assign o_vld  = r_vld;
  assign o_data = r_flit_out[FLIT_W-1:2];
  assign o_head = r_flit_out[1];
  assign o_tail = r_flit_out[0];
  assign o_occ  = r_count;

  // Next-state for pointers, occupancy, packet count and the egress gate
  always_comb begin
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? PTR_ZERO : r_wr_ptr + PTR_ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? PTR_ZERO : r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_count_nxt   = r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    w_pkt_cnt_nxt = r_pkt_cnt + OCC_W'(w_push & i_tail) - OCC_W'(w_pop & r_flit_out[0]);
    // A push into a FIFO that is empty once this cycle's pop is taken
    // becomes the next head directly; memory is written only at the edge.
    if (w_push && (r_count == OCC_W'(w_pop))) begin
      w_head_ent = w_flit_in;
    end else begin
      w_head_ent = r_mem[w_rd_ptr_nxt];
    end
    if ((r_state == SEND) && w_pop && r_flit_out[0]) begin
      w_state_aft = IDLE;
    end else begin
      w_state_aft = r_state;
    end
    // Release a packet once it is complete, or force it out when the FIFO
    // is full with no complete packet, so packets longer than DEPTH pass.
    w_go = (w_count_nxt != OCC_ZERO) && w_head_ent[1] &&
           ((w_pkt_cnt_nxt != OCC_ZERO) || (w_count_nxt == DEPTH_C));
    if (PKT_MODE == PKT_MODE_SAF) begin
      case (w_state_aft)
        IDLE: begin
          w_state_nxt = w_go ? SEND : IDLE;
          w_vld_nxt   = w_go;
        end
        SEND: begin
          w_state_nxt = SEND;
          w_vld_nxt   = (w_count_nxt != OCC_ZERO);
        end
        default: begin
          w_state_nxt = IDLE;
          w_vld_nxt   = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = IDLE;
      w_vld_nxt   = (w_count_nxt != OCC_ZERO);
    end
    w_flit_out_nxt = w_vld_nxt ? w_head_ent : FLIT_ZERO;
  end

  // Control state and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_count    <= OCC_ZERO;
      r_pkt_cnt  <= OCC_ZERO;
      r_state    <= IDLE;
      r_rdy      <= 1'b0;
      r_vld      <= 1'b0;
      r_flit_out <= FLIT_ZERO;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_pkt_cnt  <= w_pkt_cnt_nxt;
      r_state    <= w_state_nxt;
      r_rdy      <= (w_count_nxt != DEPTH_C);
      r_vld      <= w_vld_nxt;
      r_flit_out <= w_flit_out_nxt;
    end
  end

  // Flit storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_flit_in;
    end
  end

`ifdef NOC_TOK_BUF_FRAME_CHK_EN
  logic       r_in_pkt;
  logic [1:0] r_err, w_err_new;

  // Framing violations seen on the accepted ingress flit
  always_comb begin
    w_err_new = 2'b00;
    if (w_push) begin
      w_err_new[FRAME_ERR_NO_TAIL] = i_head & r_in_pkt;
      w_err_new[FRAME_ERR_NO_HEAD] = ~i_head & ~r_in_pkt;
    end else begin
      w_err_new = 2'b00;
    end
  end

  // Packet framing tracker and sticky error bits (new error wins over clear)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_pkt <= 1'b0;
      r_err    <= 2'b00;
    end else begin
      if (w_push) begin
        r_in_pkt <= i_tail ? 1'b0 : (i_head ? 1'b1 : r_in_pkt);
      end
      r_err <= (i_err_clr ? 2'b00 : r_err) | w_err_new;
    end
  end

  assign o_frame_err = r_err;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_err_clr;
  assign o_frame_err  = 2'b00;
`endif

endmodule

// File: rtl/noc_tok_link_buf.sv
// noc_tok_link_buf
//   Multi-channel buffer for NoC token links. NUM_CH independent channels,
//   each a noc_tok_buf_ch with its own FIFO, cut-through (PKT_MODE=0) or
//   store-and-forward (PKT_MODE=1) egress.
//   Optional framing checker: define NOC_TOK_BUF_FRAME_CHK_EN; otherwise
//   o_frame_err is 0 and i_err_clr is ignored.
// Ports:
//   i_noc_clk, i_noc_rst_n   clock, asynchronous active-low reset
//   scan_en                  scan enable, no functional effect
//   i_ing_*/o_ing_rdy        ingress flit bundle, channel g at slice g
//   o_egr_*/i_egr_rdy        egress flit bundle
//   o_occ                    per-channel occupancy, OCC_W bits each
//   i_err_clr, o_frame_err   sticky framing error clear / 2 bits per channel
module noc_tok_link_buf
  import noc_tok_buf_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 42,
  parameter int DEPTH    = 4,
  parameter int PKT_MODE = PKT_MODE_CT,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                     i_noc_clk,
  input  logic                     i_noc_rst_n,
  input  logic                     scan_en,
  input  logic [NUM_CH*DATA_W-1:0] i_ing_data,
  input  logic [NUM_CH-1:0]        i_ing_head,
  input  logic [NUM_CH-1:0]        i_ing_tail,
  input  logic [NUM_CH-1:0]        i_ing_vld,
  output logic [NUM_CH-1:0]        o_ing_rdy,
  output logic [NUM_CH*DATA_W-1:0] o_egr_data,
  output logic [NUM_CH-1:0]        o_egr_head,
  output logic [NUM_CH-1:0]        o_egr_tail,
  output logic [NUM_CH-1:0]        o_egr_vld,
  input  logic [NUM_CH-1:0]        i_egr_rdy,
  output logic [NUM_CH*OCC_W-1:0]  o_occ,
  input  logic                     i_err_clr,
  output logic [NUM_CH*2-1:0]      o_frame_err
);

  logic w_unused_scan;
  assign w_unused_scan = scan_en;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    noc_tok_buf_ch #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .PKT_MODE(PKT_MODE)
    ) u_ch (
      .i_clk      (i_noc_clk),
      .i_rst_n    (i_noc_rst_n),
      .i_data     (i_ing_data[g*DATA_W +: DATA_W]),
      .i_head     (i_ing_head[g]),
      .i_tail     (i_ing_tail[g]),
      .i_vld      (i_ing_vld[g]),
      .o_rdy      (o_ing_rdy[g]),
      .o_data     (o_egr_data[g*DATA_W +: DATA_W]),
      .o_head     (o_egr_head[g]),
      .o_tail     (o_egr_tail[g]),
      .o_vld      (o_egr_vld[g]),
      .i_rdy      (i_egr_rdy[g]),
      .o_occ      (o_occ[g*OCC_W +: OCC_W]),
      .i_err_clr  (i_err_clr),
      .o_frame_err(o_frame_err[g*2 +: 2])
    );
  end

endmodule
